// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one display digit of a modulo-MODULUS up/down counter.
// Instances cascade by wiring one digit's co to the next digit's en, so every
// digit in the chain advances on the same clock edge (single clock domain).
// The segment pattern is registered from the next-state digit so that seg
// and digit always change on the same edge. The blank input masks the
// segment output combinationally and leaves the count untouched.

module bcd_digit_counter #(
    parameter int MODULUS        = 6,    // count range 0..MODULUS-1, legal 2..10
    parameter bit SEG_ACTIVE_LOW = 1'b1  // 1: segment lit when its bit is 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       blank,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       co,
    output logic       wrap
);

    localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);
    localparam logic [4:0] MOD_VAL = 5'(MODULUS);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    // Segment pattern {g,f,e,d,c,b,a} for a binary digit, already adjusted to
    // the board polarity. Codes 10..15 never occur in a legal state; they show
    // as a dark digit rather than garbage.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'd0:    lit = 7'b0111111;
            4'd1:    lit = 7'b0000110;
            4'd2:    lit = 7'b1011011;
            4'd3:    lit = 7'b1001111;
            4'd4:    lit = 7'b1100110;
            4'd5:    lit = 7'b1101101;
            4'd6:    lit = 7'b1111101;
            4'd7:    lit = 7'b0000111;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1101111;
            default: lit = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic       wrap_q;

    logic       in_range;
    logic       up_term;
    logic       dn_term;
    logic       load_ok;
    logic       co_int;

    // An out-of-range state is folded into the up terminal so the next up
    // tick recovers to 0; a down tick from it steps to MAX_VAL without a borrow.
    assign in_range = ({1'b0, digit_q} < MOD_VAL);
    assign up_term  = !in_range || (digit_q == MAX_VAL);
    assign dn_term  = (digit_q == 4'd0);
    assign load_ok  = ({1'b0, load_val} < MOD_VAL);

    // Carry/borrow is suppressed in reset and whenever clear or load overrides
    // the count, so a cascaded digit never sees a phantom tick.
    assign co_int = rst_n & en & ~clr & ~load & (up ? up_term : dn_term);

    // Next-state digit with priority clr > load > en > hold.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (load) begin
            digit_d = load_ok ? load_val : MAX_VAL;
        end else if (en) begin
            if (up) begin
                digit_d = up_term ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (dn_term || !in_range) ? MAX_VAL : digit_q - 4'd1;
            end
        end
        seg_d = seg_encode(digit_d);
    end

    // Count, segment and wrap-pulse registers; reset shows a lit zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
            seg_q   <= seg_encode(4'd0);
            wrap_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            seg_q   <= seg_d;
            wrap_q  <= co_int;
        end
    end

    assign digit = digit_q;
    assign seg   = blank ? SEG_OFF : seg_q;
    assign co    = co_int;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Testbench for bcd_digit_counter: a MODULUS=6 digit driven from a vector
// table, a units(10)/tens(6) chain, and an active-high MODULUS=10 digit for
// the blanking path.

module tb_bcd_digit_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    // Active-low segment patterns for digits 0..9 as listed for the board.
    logic [6:0] seg_al [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT A: MODULUS=6, active-low ----------------
    logic       a_en = 0, a_up = 0, a_clr = 0, a_load = 0, a_blank = 0;
    logic [3:0] a_lv = 0;
    logic [3:0] a_digit;
    logic [6:0] a_seg;
    logic       a_co, a_wrap;

    bcd_digit_counter #(.MODULUS(6), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .blank(a_blank),
        .digit(a_digit), .seg(a_seg), .co(a_co), .wrap(a_wrap)
    );

    // ---------------- chain: units MODULUS=10 -> tens MODULUS=6 ----------------
    logic       u_en = 0, u_up = 1, u_clr = 0, u_load = 0, u_blank = 0;
    logic [3:0] u_lv = 0;
    logic [3:0] u_digit;
    logic [6:0] u_seg;
    logic       u_co, u_wrap;
    logic [3:0] t_lv = 0;
    logic       t_blank = 0;
    logic [3:0] t_digit;
    logic [6:0] t_seg;
    logic       t_co, t_wrap;

    bcd_digit_counter #(.MODULUS(10), .SEG_ACTIVE_LOW(1'b1)) dut_units (
        .clk(clk), .rst_n(rst_n), .en(u_en), .up(u_up), .clr(u_clr),
        .load(u_load), .load_val(u_lv), .blank(u_blank),
        .digit(u_digit), .seg(u_seg), .co(u_co), .wrap(u_wrap)
    );

    bcd_digit_counter #(.MODULUS(6), .SEG_ACTIVE_LOW(1'b1)) dut_tens (
        .clk(clk), .rst_n(rst_n), .en(u_co), .up(u_up), .clr(u_clr),
        .load(u_load), .load_val(t_lv), .blank(t_blank),
        .digit(t_digit), .seg(t_seg), .co(t_co), .wrap(t_wrap)
    );

    // ---------------- DUT C: MODULUS=10, active-high ----------------
    logic       c_en = 0, c_up = 1, c_clr = 0, c_load = 0, c_blank = 0;
    logic [3:0] c_lv = 0;
    logic [3:0] c_digit;
    logic [6:0] c_seg;
    logic       c_co, c_wrap;

    bcd_digit_counter #(.MODULUS(10), .SEG_ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .clr(c_clr),
        .load(c_load), .load_val(c_lv), .blank(c_blank),
        .digit(c_digit), .seg(c_seg), .co(c_co), .wrap(c_wrap)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of DUT A: drive at the falling edge, check co before the
    // rising edge, then digit/seg/wrap just after it.
    task automatic step_a(input logic clr, input logic load, input logic en,
                          input logic up, input logic [3:0] lv,
                          input logic [3:0] exp_d, input logic exp_co,
                          input logic exp_w, input string name);
        @(negedge clk);
        a_clr = clr; a_load = load; a_en = en; a_up = up; a_lv = lv;
        #1;
        chk({name, ".co"}, {7'b0, a_co}, {7'b0, exp_co});
        @(posedge clk);
        #1;
        chk({name, ".digit"}, {4'b0, a_digit}, {4'b0, exp_d});
        chk({name, ".seg"}, {1'b0, a_seg}, {1'b0, seg_al[exp_d]});
        chk({name, ".wrap"}, {7'b0, a_wrap}, {7'b0, exp_w});
    endtask

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] exp_d;
        logic       exp_co;
        logic       exp_w;
    } vec_t;

    vec_t vecs [22];

    initial begin
        // Vector table for DUT A (MODULUS=6), starting from digit 0.
        //            clr   load  en    up    lv     digit  co    wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd4, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd5, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  4'd4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 4'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  4'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd5, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd2,  4'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd5, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd4, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  4'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd3, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd3, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd2, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd6,  4'd5, 1'b0, 1'b0};

        // ---- reset state (en held high: co must stay 0) ----
        a_en = 1'b1; a_up = 1'b1;
        @(negedge clk);
        chk("rst.digit", {4'b0, a_digit}, 8'd0);
        chk("rst.seg", {1'b0, a_seg}, {1'b0, seg_al[0]});
        chk("rst.wrap", {7'b0, a_wrap}, 8'd0);
        chk("rst.co", {7'b0, a_co}, 8'd0);
        chk("rst.seg_ah", {1'b0, c_seg}, 8'b00111111);
        a_en = 1'b0;
        rst_n = 1'b1;

        // ---- count to 3, then reset between edges ----
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "pre1");
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, "pre2");
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, "pre3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.digit", {4'b0, a_digit}, 8'd0);
        chk("midrst.seg", {1'b0, a_seg}, {1'b0, seg_al[0]});
        chk("midrst.wrap", {7'b0, a_wrap}, 8'd0);
        chk("midrst.co", {7'b0, a_co}, 8'd0);
        @(posedge clk);
        #1;
        chk("midrst.hold", {4'b0, a_digit}, 8'd0);
        @(negedge clk);
        a_en = 1'b0;
        rst_n = 1'b1;

        // ---- table-driven vectors on DUT A ----
        for (int i = 0; i < 22; i++) begin
            step_a(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv,
                   vecs[i].exp_d, vecs[i].exp_co, vecs[i].exp_w,
                   $sformatf("vec%0d", i));
        end
        @(negedge clk);
        a_en = 1'b0; a_load = 1'b0; a_clr = 1'b0;

        // ---- MODULUS=10 down count from 0 (units) ----
        u_en = 1'b1; u_up = 1'b0;
        #1;
        chk("down0.co", {7'b0, u_co}, 8'd1);
        @(posedge clk);
        #1;
        chk("down0.digit", {4'b0, u_digit}, 8'd9);
        chk("down0.seg", {1'b0, u_seg}, {1'b0, seg_al[9]});
        chk("down0.wrap", {7'b0, u_wrap}, 8'd1);
        for (int i = 8; i >= 0; i--) begin
            @(negedge clk);
            #1;
            chk($sformatf("down%0d.co", i), {7'b0, u_co}, 8'd0);
            @(posedge clk);
            #1;
            chk($sformatf("down%0d.digit", i), {4'b0, u_digit}, 8'(i));
            chk($sformatf("down%0d.wrap", i), {7'b0, u_wrap}, 8'd0);
        end

        // ---- clear both digits of the chain ----
        @(negedge clk);
        u_en = 1'b0; u_up = 1'b1; u_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("chclr.units", {4'b0, u_digit}, 8'd0);
        chk("chclr.tens", {4'b0, t_digit}, 8'd0);
        @(negedge clk);
        u_clr = 1'b0;

        // ---- chained 60-cycle up count ----
        u_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("chain%0d.uco", i), {7'b0, u_co}, {7'b0, (i % 10) == 9});
            chk($sformatf("chain%0d.tco", i), {7'b0, t_co}, {7'b0, i == 59});
            @(posedge clk);
            #1;
            chk($sformatf("chain%0d.units", i), {4'b0, u_digit}, 8'((i + 1) % 10));
            chk($sformatf("chain%0d.tens", i), {4'b0, t_digit}, 8'(((i + 1) / 10) % 6));
            chk($sformatf("chain%0d.uwrap", i), {7'b0, u_wrap}, {7'b0, (i % 10) == 9});
        end
        chk("chain.twrap", {7'b0, t_wrap}, 8'd1);
        @(negedge clk);
        u_en = 1'b0;

        // ---- active-high digit 8 with blank toggled between edges ----
        c_load = 1'b1; c_lv = 4'd8;
        @(posedge clk);
        #1;
        chk("blank.digit", {4'b0, c_digit}, 8'd8);
        chk("blank.seg0", {1'b0, c_seg}, 8'b01111111);
        c_load = 1'b0;
        c_blank = 1'b1;
        #1;
        chk("blank.seg1", {1'b0, c_seg}, 8'b00000000);
        chk("blank.digit1", {4'b0, c_digit}, 8'd8);
        c_blank = 1'b0;
        #1;
        chk("blank.seg2", {1'b0, c_seg}, 8'b01111111);
        chk("blank.digit2", {4'b0, c_digit}, 8'd8);

        // ---- active-low blank on DUT A (digit 5 held) ----
        a_blank = 1'b1;
        #1;
        chk("blank_al.seg", {1'b0, a_seg}, 8'b01111111);
        a_blank = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_digit_counter.md
# bcd_digit_counter

Parametrised single-digit modulo-N counter with up/down direction, synchronous load/clear, cascade carry/borrow and registered 7-segment drive for the MAX 10 clock displays. It is the generalised successor of the fixed-modulus tens/units stages. One instance per display digit; instances chain through `en`/`co` in a single clock domain. Chained digits replace the old ripple-clocked stages.

## Interface
Parameters:
- `MODULUS`, 6, count range 0..MODULUS-1; legal 2..10
- `SEG_ACTIVE_LOW`, 1, 1 = segment on when bit is 0 (MAX 10 board displays); 0 = active-high

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  count enable, one-cycle tick from prescaler or lower digit's `co`
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `clr`  in  1  synchronous clear to 0
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  4  value to load (binary 0..15)
- `blank`  in  1  forces all segments off, combinational, counting unaffected
- `digit`  out  4  current count, binary
- `seg`  out  7  segment pattern {g,f,e,d,c,b,a}
- `co`  out  1  cascade carry/borrow, combinational
- `wrap`  out  1  registered one-cycle pulse after a wrap occurred

## Operation
- Priority per rising edge: `clr` > `load` > `en` > hold.
- `clr`: digit <= 0.
- `load`: digit <= load_val if load_val < MODULUS, else MODULUS-1 (saturate). No `wrap` generated.
- `en` & `up`: digit <= digit+1; at MODULUS-1 wraps to 0.
- `en` & !`up`: digit <= digit-1; at 0 wraps to MODULUS-1.
- `co` = rst_n & en & !clr & !load & (up ? digit==MODULUS-1 : digit==0). Feeds next digit's `en` directly; chained digits advance on the same edge.
- `wrap` <= `co` (registered); high exactly one cycle after each wrap edge.
- `seg` registered, computed from the next-state digit, so `seg` and `digit` always change on the same edge. Active-low encodings (SEG_ACTIVE_LOW=1): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. SEG_ACTIVE_LOW=0 gives the bitwise inverse.
- `blank`=1: seg output = all-off (1111111 active-low, 0000000 active-high). The register keeps tracking.
- Out-of-range internal state (digit ≥ MODULUS, not reachable by design) is treated as terminal. The next `en` wraps it to 0 (up) or steps it to MODULUS-1 (down).

## Timing
- Reset (rst_n low, async): digit=0, seg = pattern for 0, wrap=0, co=0 forced. Takes effect immediately, mid-count included.
- Reset release: first count accepted on the first rising edge with rst_n high and en=1.
- Count latency: 1 cycle from `en` sampled high to new `digit`/`seg`.
- `co`: zero latency, valid same cycle as `en`. `wrap`: 1 cycle after the wrap edge.
- `en` held high for consecutive cycles counts every cycle; no edge detection.
- Simultaneous `clr`/`load` with `en` at terminal count: `co`=0, no wrap, clear/load wins.
- Direction change takes effect on the same edge `up` is sampled.
- `blank`: combinational only, no latency.

## Test plan
- Reset mid-count (digit=3, MODULUS=6), rst_n low between edges -> digit=0, seg=1000000, wrap=0 immediately. After release, 6 `en` ticks -> digits 1,2,3,4,5,0; `co`=1 only during the tick at 5; wrap=1 the cycle after the 5->0 edge.
- MODULUS=10, up=0, from 0 with en=1 -> digit 9, seg=0010000, `co`=1 during that tick. Next 9 ticks -> 8..0 with no `co`.
- Two chained instances (units MODULUS=10 feeding tens MODULUS=6), en tied high on units for 60 cycles -> tens steps on the same edge as units 9->0. The pair reads 00 after 60 cycles. Tens `co` high only at 59.
- `load` with load_val=4 at MODULUS=6 -> digit=4. load_val=12 -> digit=5. `clr`+`load`+`en` together -> digit=0, co=0.
- SEG_ACTIVE_LOW=0, digit=8, blank toggled 0->1->0 -> seg 1111111 -> 0000000 -> 1111111 with no clock edge, digit unchanged.
- `en` high, `up` toggled every cycle from digit=2 -> digit sequence 3,2,3,2; no `co`, no `wrap`.
